bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Parametrised, digit-serial BCD add/subtract unit processing one decimal digit per clock. Each operation is DIGITS BCD digits wide and uses a carry/borrow chain across digits. It is a multi-digit, sequential successor to the single-step decimal-adjust logic in the arithmetic datapath. It sits between the instruction issue stage and the writeback path, and uses ready/valid handshakes on both sides.

## Interface
- DIGITS, 4: number of BCD digits per operand; must be >= 1.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation this cycle.
- in_a  input  4*DIGITS  operand A; digit 0 in bits [3:0].
- in_b  input  4*DIGITS  operand B, same packing.
- in_sub  input  1  0: A+B+carry; 1: A-B-borrow.
- in_carry  input  1  carry-in (add) or borrow-in (subtract).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  4*DIGITS  BCD result, same packing.
- out_carry  output  1  final carry (add) or borrow (subtract).
- out_error  output  1  a non-BCD digit was present in an operand (see Configuration).

## Operation
- Three states:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Input handshake: in_valid&in_ready at an edge. On that edge the unit captures in_a, in_b, in_sub and in_carry. It clears the digit index and the working result, loads the chain bit from in_carry, and goes to CALC.
- CALC processes digit i (starting at 0) at each edge:
  - Add: t = a_i + b_i + c (5-bit unsigned).
    - If t > 9: digit = (t+6)[3:0], c = 1.
    - Otherwise: digit = t[3:0], c = 0.
  - Subtract: t = a_i - b_i - br (6-bit signed).
    - If t < 0: digit = (t+10)[3:0], br = 1.
    - Otherwise: digit = t[3:0], br = 0.
  - The digit is written into working result slot i, then the index increments.
- After the edge that processes digit DIGITS-1, the unit copies the working result to out_result and the chain bit to out_carry, then goes to DONE.
- out_result, out_carry and out_error change only on CALC->DONE. They hold stable through DONE and afterwards, until the next operation completes.
- DONE:
  - Output handshake out_valid&out_ready, with no simultaneous input handshake -> IDLE.
  - Both handshakes on the same edge -> new operation captured, straight to CALC.
- Non-BCD operand digits (>9) use the same formulas; the result is defined but not meaningful.
- Reset values (asynchronous, while rst=1): state IDLE, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_error=0, working registers 0.
- Reset mid-operation abandons the operation; no result is produced.

## Timing
- Latency: input accepted at edge E; out_valid=1 in the cycle after edge E+DIGITS.
- Throughput: one operation per DIGITS+1 cycles when out_ready is held high, using the overlapped DONE->CALC path.
- in_ready is combinational from state and out_ready. It has no combinational path from in_valid.
- out_valid is a pure state decode.
- DIGITS=1: CALC lasts one cycle; the rules are otherwise unchanged.

## Configuration
- BCD_SERIAL_ADDER_DIGIT_CHECK_EN
  - Defined:
    - During CALC, out_error's working flag is set if a_i > 9 or b_i > 9 for any processed digit.
    - The flag is cleared on input handshake and is presented with the result.
  - Not defined:
    - out_error is tied to 0 and no check logic is built.
    - Arithmetic is identical in both builds.

## Test plan
- DIGITS=4, add 0x1234 + 0x5678, carry 0:
  - out_result=0x6912, out_carry=0.
  - out_valid first high exactly 4 edges after the accept edge.
- Add 0x9999 + 0x0001, carry 0 -> out_result=0x0000, out_carry=1.
- Add 0x0000 + 0x0000, carry 1 -> 0x0001, carry 0.
- Subtract 0x0000 - 0x0001, borrow 0 -> out_result=0x9999, out_carry=1.
- Subtract 0x5000 - 0x1234 -> 0x3766, out_carry=0.
- Backpressure and overlap:
  - Hold out_ready=0 for 3 cycles in DONE: out_valid and out_result stay stable, in_ready=0.
  - Then raise out_ready with in_valid=1: both handshakes on one edge, next result valid 4 edges later.
- Reset mid-operation: assert rst for 1 cycle during digit 2 of CALC.
  - Required: out_valid=0, in_ready=1, all outputs 0.
  - A following add 0x0005 + 0x0005 -> 0x0010, carry 0.
- Digit check: add 0x00A0 + 0x0000.
  - With the macro defined: out_error=1.
  - Without the macro: out_error=0.
  - out_result is identical in both builds.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// Request/result bus of the digit-serial BCD add/subtract unit.
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high; the source holds its payload and valid stable
// until that edge, and ready never depends combinationally on valid.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_a;
  logic [4*DIGITS-1:0]   in_b;
  logic                  in_sub;
  logic                  in_carry;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_result;
  logic                  out_carry;
  logic                  out_error;

  // Issue/writeback side: issues requests and consumes results.
  modport master (
    output in_valid, in_a, in_b, in_sub, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_error
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_error
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract unit: one decimal digit per clock, with a
// carry/borrow chain carried across digits. Result registers only change
// when an operation completes.
// Optional feature: define BCD_SERIAL_ADDER_DIGIT_CHECK_EN to flag operand
// digits greater than 9 on out_error; otherwise out_error is tied to 0.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_adder_if.slave     bus,
  output logic [1:0]            dbg_state
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_next;
  logic [4*DIGITS-1:0]   a_q, b_q, work, result;
  logic                  sub_q, chain, carry;
  logic [IDXW-1:0]       idx;

  logic                  accept, last;
  logic [3:0]            a_i, b_i, digit;
  logic                  chain_next;
  logic [4:0]            sum;
  logic [5:0]            diff;
  logic [4*DIGITS-1:0]   work_next;

  assign accept       = bus.in_valid & bus.in_ready;
  assign last         = (idx == LAST_IDX);
  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result;
  assign bus.out_carry  = carry;
  assign dbg_state      = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: DONE can hand straight back to CALC when both handshakes coincide.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = CALC;
      CALC: if (last) state_next = DONE;
      DONE: begin
        if (bus.out_ready && bus.in_valid) state_next = CALC;
        else if (bus.out_ready)            state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of add (decimal adjust by +6) or subtract (adjust by +10).
  always_comb begin
    a_i        = a_q[idx*4 +: 4];
    b_i        = b_q[idx*4 +: 4];
    sum        = {1'b0, a_i} + {1'b0, b_i} + {4'b0, chain};
    diff       = {2'b0, a_i} - {2'b0, b_i} - {5'b0, chain};
    digit      = 4'd0;
    chain_next = 1'b0;
    if (!sub_q) begin
      if (sum > 5'd9) begin
        digit      = sum[3:0] + 4'd6;
        chain_next = 1'b1;
      end else begin
        digit      = sum[3:0];
      end
    end else begin
      if (diff[5]) begin
        digit      = diff[3:0] + 4'd10;
        chain_next = 1'b1;
      end else begin
        digit      = diff[3:0];
      end
    end
    work_next = work;
    work_next[idx*4 +: 4] = digit;
  end

  // Operand capture, digit iteration and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      chain  <= 1'b0;
      idx    <= '0;
      work   <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.in_a;
      b_q    <= bus.in_b;
      sub_q  <= bus.in_sub;
      chain  <= bus.in_carry;
      idx    <= '0;
      work   <= '0;
    end else if (state == CALC) begin
      work  <= work_next;
      chain <= chain_next;
      idx   <= idx + IDXW'(1);
      if (last) begin
        result <= work_next;
        carry  <= chain_next;
      end
    end
  end

`ifdef BCD_SERIAL_ADDER_DIGIT_CHECK_EN
  logic err_work, error, bad_digit;

  assign bad_digit     = (a_i > 4'd9) || (b_i > 4'd9);
  assign bus.out_error = error;

  // Sticky non-BCD flag, presented together with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_work <= 1'b0;
      error    <= 1'b0;
    end else if (accept) begin
      err_work <= 1'b0;
    end else if (state == CALC) begin
      err_work <= err_work | bad_digit;
      if (last) error <= err_work | bad_digit;
    end
  end
`else
  assign bus.out_error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): vector table plus
// backpressure/overlap and mid-operation reset sequences.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_result;
    logic         exp_carry;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge and wait (bounded) for the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_carry = cin;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready never rose");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid shows, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: out_valid never rose");
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;

    //                a        b        sub   cin   result   carry err
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[4] = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0};
`ifdef BCD_SERIAL_ADDER_DIGIT_CHECK_EN
    vecs[5] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1};
`else
    vecs[5] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
`endif
    vecs[6] = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h0098, 1'b0, 1'b0};
    vecs[7] = '{16'h4567, 16'h5432, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_carry", bus.out_carry, 0);
    check("rst_error", bus.out_error, 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), lat, DIGITS);
      check($sformatf("v%0d_result", i), bus.out_result, vecs[i].exp_result);
      check($sformatf("v%0d_carry", i), bus.out_carry, vecs[i].exp_carry);
      check($sformatf("v%0d_error", i), bus.out_error, vecs[i].exp_err);
      drain();
      check($sformatf("v%0d_idle", i), bus.out_valid, 0);
    end

    // Backpressure: hold out_ready low for 3 cycles in DONE.
    issue(16'h1234, 16'h5678, 1'b0, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_result", bus.out_result, 16'h6912);
    end
    // Overlap: both handshakes on the same edge.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h0005;
    bus.in_b      = 16'h0005;
    bus.in_sub    = 1'b0;
    bus.in_carry  = 1'b0;
    #1 check("ov_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("ov_calc_valid", bus.out_valid, 0);
    check("ov_result_hold", bus.out_result, 16'h6912);
    wait_result(lat);
    check("ov_latency", lat, DIGITS);
    check("ov_result", bus.out_result, 16'h0010);
    check("ov_carry", bus.out_carry, 0);
    drain();

    // Reset during digit 2 of CALC.
    issue(16'h9999, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_in_ready", bus.in_ready, 1);
    check("mr_result", bus.out_result, 0);
    check("mr_carry", bus.out_carry, 0);
    check("mr_error", bus.out_error, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0005, 16'h0005, 1'b0, 1'b0);
    wait_result(lat);
    check("mr_after_latency", lat, DIGITS);
    check("mr_after_result", bus.out_result, 16'h0010);
    check("mr_after_carry", bus.out_carry, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
